// File: rtl/Function_Unit_pkg.sv
// Function_Unit shared types: result layout, checker state, flag masks, golden ALU model.
package Function_Unit_pkg;

    typedef struct packed {
        logic [15:0] f;
        logic        v;
        logic        c;
        logic        n;
        logic        z;
    } exp_t;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        FAILED = 2'd1,
        HALT   = 2'd2
    } chk_state_t;

    typedef enum logic [1:0] {
        Add = 2'd0,
        Sub = 2'd1,
        And = 2'd2,
        Xor = 2'd3
    } alu_op_t;

    localparam logic [3:0] MaskV   = 4'b1000;
    localparam logic [3:0] MaskC   = 4'b0100;
    localparam logic [3:0] MaskN   = 4'b0010;
    localparam logic [3:0] MaskZ   = 4'b0001;
    localparam logic [3:0] MaskAll = MaskV | MaskC | MaskN | MaskZ;

    // Flag nibble in mask order {v,c,n,z}
    function automatic logic [3:0] flags_of(input exp_t e);
        return {e.v, e.c, e.n, e.z};
    endfunction

    // Golden ALU result; c is carry-out for Add and borrow for Sub
    function automatic exp_t model_alu(input logic [15:0] a, input logic [15:0] b,
                                       input alu_op_t op, input logic cin);
        exp_t        r;
        logic [16:0] s;
        r = '0;
        s = '0;
        case (op)
            Add: begin
                s   = {1'b0, a} + {1'b0, b} + 17'(cin);
                r.f = s[15:0];
                r.c = s[16];
                r.v = (a[15] == b[15]) && (r.f[15] != a[15]);
            end
            Sub: begin
                s   = {1'b0, a} - {1'b0, b} - 17'(cin);
                r.f = s[15:0];
                r.c = s[16];
                r.v = (a[15] != b[15]) && (r.f[15] != a[15]);
            end
            And:     r.f = a & b;
            default: r.f = a ^ b;
        endcase
        r.n = r.f[15];
        r.z = (r.f == 16'h0000);
        return r;
    endfunction

endpackage

// File: rtl/fu_exp_fifo.sv
// Expected-result FIFO: DEPTH x exp_t, wrap-bit pointers, synchronous flush.
module fu_exp_fifo
    import Function_Unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  exp_t                     push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output exp_t                     head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    exp_t        r_mem [DEPTH];

    logic        w_push;
    logic        w_pop;

    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    assign level = r_wr_ptr - r_rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fu_result_checker.sv
// In-line scoreboard: compares observed Function_Unit results against queued expectations.
// Optional macro FU_CHK_STOP_ON_FAIL_EN: halt checking on the first failure until clear.
module fu_result_checker
    import Function_Unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  exp_t                     exp_data,
    input  logic                     obs_valid,
    input  exp_t                     obs_data,
    input  logic [3:0]               flag_mask,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     orphan,
    output logic                     err_sticky,
    output exp_t                     first_fail_exp,
    output exp_t                     first_fail_obs,
    output logic [CNT_W-1:0]         first_fail_idx,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     halted
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    chk_state_t        r_state;
    logic [CNT_W-1:0]  r_pass;
    logic [CNT_W-1:0]  r_fail;
    logic              r_orphan;
    logic              r_err;
    exp_t              r_ff_exp;
    exp_t              r_ff_obs;
    logic [CNT_W-1:0]  r_ff_idx;

    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;
    exp_t              w_head;
    logic              w_push;
    logic              w_obs;
    logic              w_pop;
    logic              w_match;
    logic              w_pass;
    logic              w_fail;
    logic [CNT_W:0]    w_idx_sum;
    logic [CNT_W-1:0]  w_idx;

    assign w_push  = exp_valid && exp_ready && !clear;
    assign w_obs   = obs_valid && !clear && (r_state != HALT);
    assign w_pop   = w_obs && !w_empty;
    assign w_match = (obs_data.f == w_head.f) &&
                     (((flags_of(obs_data) ^ flags_of(w_head)) & flag_mask) == 4'b0000);
    assign w_pass  = w_pop && w_match;
    assign w_fail  = w_obs && (w_empty || !w_match);

    assign w_idx_sum = {1'b0, r_pass} + {1'b0, r_fail};
    assign w_idx     = w_idx_sum[CNT_W] ? '1 : w_idx_sum[CNT_W-1:0];

    fu_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear),
        .push      (w_push),
        .push_data (exp_data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .level     (w_level),
        .head      (w_head)
    );

`ifdef FU_CHK_STOP_ON_FAIL_EN
    logic r_halted;
    assign halted = r_halted;

    // Halt flag follows the first failure and holds until clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_halted <= 1'b0;
        else if (clear)  r_halted <= 1'b0;
        else if (w_fail) r_halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

    // Checker FSM with saturating counters and first-failure capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CLEAN;
            r_pass   <= '0;
            r_fail   <= '0;
            r_orphan <= 1'b0;
            r_err    <= 1'b0;
            r_ff_exp <= '0;
            r_ff_obs <= '0;
            r_ff_idx <= '0;
        end else if (clear) begin
            r_state  <= CLEAN;
            r_pass   <= '0;
            r_fail   <= '0;
            r_orphan <= 1'b0;
            r_err    <= 1'b0;
            r_ff_exp <= '0;
            r_ff_obs <= '0;
            r_ff_idx <= '0;
        end else begin
            if (w_pass && (r_pass != '1)) r_pass <= r_pass + CNT_W'(1);
            if (w_fail && (r_fail != '1)) r_fail <= r_fail + CNT_W'(1);
            if (w_obs && w_empty)         r_orphan <= 1'b1;
            if (w_fail) begin
                r_err <= 1'b1;
                if (r_state == CLEAN) begin
                    r_ff_exp <= w_empty ? '0 : w_head;
                    r_ff_obs <= obs_data;
                    r_ff_idx <= w_idx;
                end
`ifdef FU_CHK_STOP_ON_FAIL_EN
                r_state <= HALT;
`else
                r_state <= FAILED;
`endif
            end
        end
    end

    assign exp_ready      = !w_full && !halted;
    assign pass_cnt       = r_pass;
    assign fail_cnt       = r_fail;
    assign orphan         = r_orphan;
    assign err_sticky     = r_err;
    assign first_fail_exp = r_ff_exp;
    assign first_fail_obs = r_ff_obs;
    assign first_fail_idx = r_ff_idx;
    assign level          = w_level;

endmodule

// File: tb/tb_fu_result_checker.sv
// Directed scoreboard bench for fu_result_checker (DEPTH=8, CNT_W=4 to reach saturation).
module tb_fu_result_checker;
    import Function_Unit_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             exp_valid;
    logic             exp_ready;
    exp_t             exp_data;
    logic             obs_valid;
    exp_t             obs_data;
    logic [3:0]       flag_mask;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             orphan;
    logic             err_sticky;
    exp_t             first_fail_exp;
    exp_t             first_fail_obs;
    logic [CNT_W-1:0] first_fail_idx;
    logic [3:0]       level;
    logic             halted;

    fu_result_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .obs_valid(obs_valid), .obs_data(obs_data), .flag_mask(flag_mask),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .orphan(orphan), .err_sticky(err_sticky),
        .first_fail_exp(first_fail_exp), .first_fail_obs(first_fail_obs),
        .first_fail_idx(first_fail_idx), .level(level), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    exp_t m_q[$];
    int   m_pass, m_fail, m_idx;
    bit   m_orphan, m_err, m_halted;
    exp_t m_ffe, m_ffo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_idx = 0;
        m_orphan = 0; m_err = 0; m_halted = 0;
        m_ffe = '0; m_ffo = '0;
    endtask

    task automatic m_record_fail(input exp_t e, input exp_t o);
        if (!m_err) begin
            m_ffe = e;
            m_ffo = o;
            m_idx = (m_pass + m_fail > CMAX) ? CMAX : m_pass + m_fail;
        end
        m_err = 1;
`ifdef FU_CHK_STOP_ON_FAIL_EN
        m_halted = 1;
`endif
        if (m_fail < CMAX) m_fail++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pass"},   32'(pass_cnt),       32'(m_pass));
        chk({tag, ".fail"},   32'(fail_cnt),       32'(m_fail));
        chk({tag, ".orphan"}, 32'(orphan),         32'(m_orphan));
        chk({tag, ".err"},    32'(err_sticky),     32'(m_err));
        chk({tag, ".ffe"},    32'(first_fail_exp), 32'(m_ffe));
        chk({tag, ".ffo"},    32'(first_fail_obs), 32'(m_ffo));
        chk({tag, ".ffi"},    32'(first_fail_idx), 32'(m_idx));
        chk({tag, ".level"},  32'(level),          32'(m_q.size()));
        chk({tag, ".halted"}, 32'(halted),         32'(m_halted));
        chk({tag, ".ready"},  32'(exp_ready),      32'((m_q.size() < DEPTH) && !m_halted));
    endtask

    // One clock of stimulus, then model update and full comparison
    task automatic step(input string tag, input bit pv, input exp_t pd, input bit ov,
                        input exp_t od, input logic [3:0] mk, input bit clr);
        bit   acc, match;
        exp_t e;
        @(negedge clk);
        exp_valid = pv; exp_data = pd; obs_valid = ov; obs_data = od;
        flag_mask = mk; clear = clr;
        acc = pv && (m_q.size() < DEPTH) && !m_halted;
        @(posedge clk);
        #1;
        if (clr) begin
            m_reset();
        end else begin
            if (ov && !m_halted) begin
                if (m_q.size() == 0) begin
                    m_orphan = 1;
                    m_record_fail('0, od);
                end else begin
                    e = m_q.pop_front();
                    match = (od.f == e.f) &&
                            (((flags_of(od) ^ flags_of(e)) & mk) == 4'b0000);
                    if (match) begin
                        if (m_pass < CMAX) m_pass++;
                    end else begin
                        m_record_fail(e, od);
                    end
                end
            end
            if (acc) m_q.push_back(pd);
        end
        exp_valid = 0; obs_valid = 0; clear = 0;
        check_all(tag);
    endtask

    exp_t a0, a1, a2, x, o;

    initial begin
        rst_n = 0; clear = 0; exp_valid = 0; obs_valid = 0;
        exp_data = '0; obs_data = '0; flag_mask = MaskAll;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // Three golden-model results matched with full mask
        a0 = model_alu(16'h7FFF, 16'h0001, Add, 1'b0);
        a1 = model_alu(16'h0003, 16'h0005, Sub, 1'b0);
        a2 = model_alu(16'hF0F0, 16'hF0F0, Xor, 1'b0);
        chk("golden.add", 32'(a0), 32'({16'h8000, 4'b1010}));
        step("t1.push0", 1, a0, 0, '0, MaskAll, 0);
        step("t1.push1", 1, a1, 0, '0, MaskAll, 0);
        step("t1.push2", 1, a2, 0, '0, MaskAll, 0);
        step("t1.obs0", 0, '0, 1, a0, MaskAll, 0);
        step("t1.obs1", 0, '0, 1, a1, MaskAll, 0);
        step("t1.obs2", 0, '0, 1, a2, MaskAll, 0);
        chk("t1.pass3", 32'(pass_cnt), 32'd3);
        chk("t1.fail0", 32'(fail_cnt), 32'd0);
        chk("t1.err0",  32'(err_sticky), 32'd0);

        // Overflow flag mismatch, then masked-out overflow
        step("t2.clear", 0, '0, 0, '0, MaskAll, 1);
        x = '{f:16'h8000, v:1'b1, c:1'b0, n:1'b1, z:1'b0};
        o = x; o.v = 1'b0;
        step("t2.push", 1, x, 0, '0, MaskAll, 0);
        step("t2.obs",  0, '0, 1, o, MaskAll, 0);
        chk("t2.fail1", 32'(fail_cnt), 32'd1);
        chk("t2.idx0",  32'(first_fail_idx), 32'd0);
        chk("t2.ffe",   32'(first_fail_exp), 32'h80008 | 32'h2);
        step("t2.push2", 1, x, 0, '0, MaskAll, 0);
        step("t2.obs2",  0, '0, 1, o, 4'h7, 0);
`ifndef FU_CHK_STOP_ON_FAIL_EN
        chk("t2.maskpass", 32'(pass_cnt), 32'd1);
`endif

        // Orphan with simultaneous push
        step("t3.clear", 0, '0, 0, '0, MaskAll, 1);
        step("t3.orphan", 1, a0, 1, a1, MaskAll, 0);
        chk("t3.orphan1", 32'(orphan), 32'd1);
        chk("t3.ffe0",    32'(first_fail_exp), 32'd0);
        chk("t3.level1",  32'(level), 32'd1);

        // Fill, refused push on full, then pointer wrap at steady level
        step("t4.clear", 0, '0, 0, '0, MaskAll, 1);
        for (int i = 0; i < DEPTH; i++)
            step("t4.fill", 1, model_alu(16'(i), 16'h0100, Add, 1'b0), 0, '0, MaskAll, 0);
        chk("t4.notready", 32'(exp_ready), 32'd0);
        step("t4.fullpp", 1, a2, 1, m_q[0], MaskAll, 0);
        chk("t4.level7", 32'(level), 32'd7);
        for (int i = 0; i < DEPTH; i++)
            step("t4.wrap", 1, model_alu(16'(i), 16'h0007, Sub, 1'b1), 1, m_q[0], MaskAll, 0);
        chk("t4.level7b", 32'(level), 32'd7);
        chk("t4.pass9",   32'(pass_cnt), 32'd9);

        // Mismatches at compare index 2 and 5
        step("t5.clear", 0, '0, 0, '0, MaskAll, 1);
        for (int i = 0; i < 6; i++)
            step("t5.push", 1, model_alu(16'(i * 3), 16'h1111, Add, 1'b0), 0, '0, MaskAll, 0);
        for (int i = 0; i < 6; i++) begin
            o = m_q.size() > 0 ? m_q[0] : exp_t'('0);
            if (i == 2 || i == 5) o.f = ~o.f;
            step("t5.obs", 0, '0, 1, o, MaskAll, 0);
        end
        chk("t5.idx2", 32'(first_fail_idx), 32'd2);
`ifdef FU_CHK_STOP_ON_FAIL_EN
        chk("t5.halted", 32'(halted), 32'd1);
        chk("t5.frozen", 32'(pass_cnt), 32'd2);
`else
        chk("t5.fail2", 32'(fail_cnt), 32'd2);
        chk("t5.pass4", 32'(pass_cnt), 32'd4);
`endif
        step("t5.clear2", 0, '0, 0, '0, MaskAll, 1);
        chk("t5.clr.pass", 32'(pass_cnt), 32'd0);
        chk("t5.clr.err",  32'(err_sticky), 32'd0);

        // Counter saturation
        step("t6.push", 1, a0, 0, '0, MaskAll, 0);
        for (int i = 0; i < 17; i++)
            step("t6.pp", 1, model_alu(16'(i), 16'(i), Xor, 1'b0), 1, m_q[0], MaskAll, 0);
        chk("t6.passsat", 32'(pass_cnt), 32'(CMAX));
        o = m_q[0]; o.z = ~o.z;
        step("t6.miss", 0, '0, 1, o, MaskZ, 0);
        chk("t6.idxsat", 32'(first_fail_idx), 32'(CMAX));
`ifndef FU_CHK_STOP_ON_FAIL_EN
        for (int i = 0; i < 20; i++)
            step("t6.orph", 0, '0, 1, a1, MaskAll, 0);
        chk("t6.failsat", 32'(fail_cnt), 32'(CMAX));
`endif

        // Asynchronous reset mid-stream
        step("t7.clear", 0, '0, 0, '0, MaskAll, 1);
        for (int i = 0; i < 4; i++)
            step("t7.push", 1, a1, 0, '0, MaskAll, 0);
        chk("t7.level4", 32'(level), 32'd4);
        #2;
        rst_n = 0;
        m_reset();
        #1;
        chk("t7.level0", 32'(level), 32'd0);
        check_all("t7.rst");
        @(negedge clk);
        rst_n = 1;
        step("t7.orphan", 0, '0, 1, a1, MaskAll, 0);
        chk("t7.orphan1", 32'(orphan), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_result_checker.md
# fu_result_checker

Synthesizable in-line scoreboard for the Function_Unit. A bench or on-chip sequencer pushes expected `exp_t` results, produced by the package golden models, into an internal FIFO. The checker then consumes the DUT's observed results in issue order, compares each against the oldest expected entry, and maintains pass/fail counters and a first-failure capture. It sits downstream of the Function_Unit outputs and is the consuming end of the expected-result stream.

## Interface
Parameters:
- `DEPTH`, 8, expected-FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of all counters

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush of FIFO, counters, captures and state
- `exp_valid`  in  1  expected entry offered
- `exp_ready`  out  1  FIFO can accept
- `exp_data`  in  20  `exp_t` {f[15:0], v, c, n, z}
- `obs_valid`  in  1  DUT result present this cycle; always consumed, no backpressure
- `obs_data`  in  20  observed result in `exp_t` layout
- `flag_mask`  in  4  compare enables {v,c,n,z}; `f` is always compared
- `pass_cnt`  out  CNT_W  matched results
- `fail_cnt`  out  CNT_W  mismatches plus orphans
- `orphan`  out  1  sticky: obs arrived with FIFO empty
- `err_sticky`  out  1  sticky: any failure since reset/clear
- `first_fail_exp`  out  20  expected entry of the first failure (0 for orphan)
- `first_fail_obs`  out  20  observed entry of the first failure
- `first_fail_idx`  out  CNT_W  compare index (pass_cnt+fail_cnt before increment) of the first failure
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `halted`  out  1  checker stopped (macro-dependent)

## Operation
- Push: `exp_valid && exp_ready`. `exp_ready = !full && !halted`. A push is not accepted when the FIFO is full, even if a pop occurs in the same cycle.
- Compare on `obs_valid`:
  - FIFO non-empty: pop the head. Match when `obs.f == exp.f` and every masked flag is equal. A match increments `pass_cnt`; a mismatch increments `fail_cnt`.
  - FIFO empty: orphan. Increment `fail_cnt` and set `orphan`. There is no bypass; a push in the same cycle does not satisfy the obs.
- State `chk_state_t`:
  - CLEAN: no failure yet.
  - FAILED: first failure captured; later failures only count.
  - HALT: only with the macro.
- Transitions:
  - CLEAN→FAILED on the first failure. Capture exp, obs and idx, and set `err_sticky`.
  - FAILED→FAILED on later failures; captures are unchanged.
  - Any state→CLEAN on `clear`.
- Counters saturate at 2^CNT_W−1 and do not wrap. `first_fail_idx` also saturates.
- Pointer wrap is modulo DEPTH. `level` is derived from pointers that carry an extra wrap bit, so full and empty are distinguishable.

## Timing
- Reset values: all counters 0, FIFO empty, `level` 0, captures 0, `orphan`/`err_sticky`/`halted` 0, state CLEAN, `exp_ready` 1.
- Compare is combinational against the head entry in the cycle of `obs_valid`. Counters, flags, captures and state update at that clock edge and are visible the next cycle (1-cycle latency).
- A push and a pop in the same cycle leave `level` unchanged.
- `clear` has priority over a same-cycle push or obs; both are dropped. All outputs take their reset values one cycle later.
- Reset asserted mid-stream drops all FIFO contents and state immediately, asynchronously.

## Configuration
- `FU_CHK_STOP_ON_FAIL_EN` defined:
  - The first failure moves the checker to HALT and asserts `halted`.
  - In HALT, `exp_ready` is 0, and obs is ignored, with counters and the FIFO frozen, until `clear`.
- Not defined: HALT is unreachable, `halted` is tied to 0, and checking continues in FAILED.

## Structure
- Package additions to `Function_Unit_pkg`:
  - `chk_state_t` enum {CLEAN, FAILED, HALT}.
  - Flag-mask localparams `MaskV`/`MaskC`/`MaskN`/`MaskZ` (4'b1000..4'b0001) and `MaskAll`.
  - `exp_t` is reused for the obs layout.
- Sub-module `fu_exp_fifo`:
  - Parameterized DEPTH × `exp_t` synchronous FIFO with flush.
  - Exposes push/pop/full/empty/level/head.
  - The top holds compare logic, FSM, counters and captures.

## Test plan
- Push 3 entries from `model_alu(16'h7FFF,16'h0001,Add,0)` etc., then feed 3 matching obs with mask 4'hF → `pass_cnt`=3, `fail_cnt`=0, `level`=0, `err_sticky`=0.
- Push `f`=16'h8000, v=1. Obs `f`=16'h8000, v=0:
  - mask 4'hF → `fail_cnt`=1, `first_fail_idx`=0, captures hold both words.
  - repeated with mask 4'h7 → pass.
- obs_valid with FIFO empty → `orphan`=1, `fail_cnt`=1, `first_fail_exp`=0. A push in the same cycle lands, and `level`=1 afterward.
- Fill DEPTH=8 entries → `exp_ready`=0. Push+obs in the same cycle → push refused, `level`=7. Then 8 further push/pop cycles exercise pointer wrap with `level` stable.
- Mismatch at index 2 then mismatch at index 5 → captures still show index 2. With `FU_CHK_STOP_ON_FAIL_EN`, `halted`=1 after index 2, and later obs leave the counters frozen. `clear` then returns CLEAN with all zeros.
- Assert `rst_n`=0 with 4 entries queued → `level`=0 immediately. After release, an obs yields an orphan.
